// File: rtl/seq_mon_pkg.sv
// Shared types for the sequence monitor: FSM states, operating mode and one step-table entry.
// Table fields use fixed maximum widths so the struct stays independent of module parameters.
package seq_mon_pkg;

    localparam int SEL_WM = 8;
    localparam int DLY_WM = 16;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        WAIT = 1'b1
    } state_e;

    typedef enum logic [0:0] {
        MODE_ASSERT = 1'b0,
        MODE_COVER  = 1'b1
    } mode_e;

    typedef struct packed {
        logic [SEL_WM-1:0] sel;
        logic [DLY_WM-1:0] min;
        logic [DLY_WM-1:0] max;
    } step_cfg_t;

endpackage

// File: rtl/sat_counter.sv
// Up-counter that sticks at all-ones instead of wrapping.
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         inc,
    output logic [W-1:0] q
);

    logic [W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (inc && (cnt_q != '1)) cnt_d = cnt_q + W'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end

    assign q = cnt_q;

endmodule

// File: rtl/seq_monitor.sv
// On-chip ordered-event checker: a trigger event followed by N_STEPS-1 events, each within a
// programmable [min,max] cycle window of the previous match. Reports pass/fail pulses and counts.
module seq_monitor
    import seq_mon_pkg::*;
#(
    parameter  int N_EV    = 4,
    parameter  int N_STEPS = 4,
    parameter  int DLY_W   = 4,
    parameter  int CNT_W   = 16,
    localparam int SEL_W   = (N_EV > 1) ? $clog2(N_EV) : 1,
    localparam int STEP_W  = $clog2(N_STEPS + 1)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     en,
    input  logic                     mode,
    input  logic                     cfg_we,
    input  logic [N_STEPS*SEL_W-1:0] cfg_sel,
    input  logic [N_STEPS*DLY_W-1:0] cfg_min,
    input  logic [N_STEPS*DLY_W-1:0] cfg_max,
    input  logic [N_EV-1:0]          ev,
    output logic                     busy,
    output logic [STEP_W-1:0]        cur_step,
    output logic                     pass,
    output logic                     fail,
    output logic [STEP_W-1:0]        fail_step,
    output logic                     abort,
    output logic                     cfg_err,
    output logic [CNT_W-1:0]         pass_cnt,
    output logic [CNT_W-1:0]         fail_cnt
);

    state_e            state_q, state_d;
    logic [STEP_W-1:0] step_q, step_d;
    logic [DLY_W-1:0]  dcnt_q, dcnt_d;
    step_cfg_t         tbl_q [N_STEPS];
    step_cfg_t         tbl_d [N_STEPS];
    logic              cfg_err_q, cfg_err_d;
    logic              pass_q, pass_d;
    logic              fail_q, fail_d;
    logic              abort_q, abort_d;
    logic [STEP_W-1:0] fail_step_q, fail_step_d;
    step_cfg_t         cur_cfg;
    logic              hit;
    logic              in_window;

    function automatic step_cfg_t default_cfg(input int k);
        step_cfg_t c;
        c.sel = SEL_WM'(k % N_EV);
        c.min = DLY_WM'(1);
        c.max = DLY_WM'(1);
        return c;
    endfunction

    function automatic logic ev_hit(input logic [N_EV-1:0] e, input logic [SEL_WM-1:0] s);
        logic h;
        h = 1'b0;
        for (int i = 0; i < N_EV; i++)
            if (s == SEL_WM'(i)) h = e[i];
        return h;
    endfunction

    // Step 0 is the trigger, so its window fields never take part in validation.
    function automatic logic table_invalid(input logic [N_STEPS*DLY_W-1:0] mn,
                                           input logic [N_STEPS*DLY_W-1:0] mx);
        logic bad;
        bad = 1'b0;
        for (int k = 1; k < N_STEPS; k++)
            if ((mn[k*DLY_W +: DLY_W] == '0) || (mn[k*DLY_W +: DLY_W] > mx[k*DLY_W +: DLY_W]))
                bad = 1'b1;
        return bad;
    endfunction

    always_comb begin
        cur_cfg = tbl_q[0];
        for (int k = 0; k < N_STEPS; k++)
            if (step_q == STEP_W'(k)) cur_cfg = tbl_q[k];
        hit       = ev_hit(ev, cur_cfg.sel);
        in_window = (DLY_WM'(dcnt_q) >= cur_cfg.min) && (DLY_WM'(dcnt_q) <= cur_cfg.max);

        state_d     = state_q;
        step_d      = step_q;
        dcnt_d      = dcnt_q;
        tbl_d       = tbl_q;
        cfg_err_d   = cfg_err_q;
        fail_step_d = fail_step_q;
        pass_d      = 1'b0;
        fail_d      = 1'b0;
        abort_d     = 1'b0;

        if (cfg_we) begin
            for (int k = 0; k < N_STEPS; k++) begin
                tbl_d[k].sel = SEL_WM'(cfg_sel[k*SEL_W +: SEL_W]);
                tbl_d[k].min = DLY_WM'(cfg_min[k*DLY_W +: DLY_W]);
                tbl_d[k].max = DLY_WM'(cfg_max[k*DLY_W +: DLY_W]);
            end
            cfg_err_d = table_invalid(cfg_min, cfg_max);
            abort_d   = (state_q == WAIT);
            state_d   = IDLE;
            step_d    = '0;
            dcnt_d    = '0;
        end else if (!en) begin
            abort_d = (state_q == WAIT);
            state_d = IDLE;
            step_d  = '0;
            dcnt_d  = '0;
        end else if (state_q == IDLE) begin
            // The cycle that shows a pass/fail/abort pulse is still the return-to-idle cycle.
            if (!cfg_err_q && hit && !(pass_q || fail_q || abort_q)) begin
                if (N_STEPS == 1) begin
                    pass_d = 1'b1;
                end else begin
                    state_d = WAIT;
                    step_d  = STEP_W'(1);
                    dcnt_d  = DLY_W'(1);
                end
            end
        end else begin
            if (hit && in_window) begin
                if (step_q == STEP_W'(N_STEPS - 1)) begin
                    pass_d  = 1'b1;
                    state_d = IDLE;
                    step_d  = '0;
                    dcnt_d  = '0;
                end else begin
                    step_d = step_q + STEP_W'(1);
                    dcnt_d = DLY_W'(1);
                end
            end else if (DLY_WM'(dcnt_q) == cur_cfg.max) begin
                state_d = IDLE;
                step_d  = '0;
                dcnt_d  = '0;
                if (mode_e'(mode) == MODE_ASSERT) begin
                    fail_d      = 1'b1;
                    fail_step_d = step_q;
                end
            end else begin
                dcnt_d = dcnt_q + DLY_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            step_q      <= '0;
            dcnt_q      <= '0;
            cfg_err_q   <= 1'b0;
            pass_q      <= 1'b0;
            fail_q      <= 1'b0;
            abort_q     <= 1'b0;
            fail_step_q <= '0;
            for (int k = 0; k < N_STEPS; k++) tbl_q[k] <= default_cfg(k);
        end else begin
            state_q     <= state_d;
            step_q      <= step_d;
            dcnt_q      <= dcnt_d;
            cfg_err_q   <= cfg_err_d;
            pass_q      <= pass_d;
            fail_q      <= fail_d;
            abort_q     <= abort_d;
            fail_step_q <= fail_step_d;
            tbl_q       <= tbl_d;
        end
    end

    sat_counter #(.W(CNT_W)) u_pass_cnt (.clk(clk), .rst_n(rst_n), .inc(pass_d), .q(pass_cnt));
    sat_counter #(.W(CNT_W)) u_fail_cnt (.clk(clk), .rst_n(rst_n), .inc(fail_d), .q(fail_cnt));

    assign busy      = (state_q == WAIT);
    assign cur_step  = step_q;
    assign pass      = pass_q;
    assign fail      = fail_q;
    assign abort     = abort_q;
    assign fail_step = fail_step_q;
    assign cfg_err   = cfg_err_q;

endmodule

// File: tb/tb_seq_monitor.sv
// Directed bench for seq_monitor: a default-width instance plus a 2-bit-counter instance on the
// same stimulus, so counter saturation is observed alongside the normal checks.
module tb_seq_monitor;

    logic        clk;
    logic        rst_n;
    logic        en;
    logic        mode;
    logic        cfg_we;
    logic [7:0]  cfg_sel;
    logic [15:0] cfg_min;
    logic [15:0] cfg_max;
    logic [3:0]  ev;

    logic        busy, pass, fail, abort, cfg_err;
    logic [2:0]  cur_step, fail_step;
    logic [15:0] pass_cnt, fail_cnt;

    logic        s_busy, s_pass, s_fail, s_abort, s_cfg_err;
    logic [2:0]  s_cur_step, s_fail_step;
    logic [1:0]  s_pass_cnt, s_fail_cnt;

    int n_cmp = 0;
    int n_err = 0;

    seq_monitor #(.N_EV(4), .N_STEPS(4), .DLY_W(4), .CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .cfg_we(cfg_we),
        .cfg_sel(cfg_sel), .cfg_min(cfg_min), .cfg_max(cfg_max), .ev(ev),
        .busy(busy), .cur_step(cur_step), .pass(pass), .fail(fail),
        .fail_step(fail_step), .abort(abort), .cfg_err(cfg_err),
        .pass_cnt(pass_cnt), .fail_cnt(fail_cnt)
    );

    seq_monitor #(.N_EV(4), .N_STEPS(4), .DLY_W(4), .CNT_W(2)) dut_s (
        .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .cfg_we(cfg_we),
        .cfg_sel(cfg_sel), .cfg_min(cfg_min), .cfg_max(cfg_max), .ev(ev),
        .busy(s_busy), .cur_step(s_cur_step), .pass(s_pass), .fail(s_fail),
        .fail_step(s_fail_step), .abort(s_abort), .cfg_err(s_cfg_err),
        .pass_cnt(s_pass_cnt), .fail_cnt(s_fail_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_cfg(input logic [7:0] s, input logic [15:0] mn, input logic [15:0] mx);
        cfg_sel = s;
        cfg_min = mn;
        cfg_max = mx;
        cfg_we  = 1'b1;
        tick();
        cfg_we  = 1'b0;
    endtask

    task automatic default_pass(input string tag);
        ev = 4'b0001; tick();
        ev = 4'b0010; tick();
        ev = 4'b0100; tick();
        ev = 4'b1000; tick();
        chk({tag, "_pass"}, 32'(pass), 32'd1);
        ev = 4'b0000; tick();
    endtask

    initial begin
        rst_n   = 1'b0;
        en      = 1'b0;
        mode    = 1'b0;
        cfg_we  = 1'b0;
        cfg_sel = '0;
        cfg_min = '0;
        cfg_max = '0;
        ev      = '0;
        #12;
        chk("rst_busy",     32'(busy),     32'd0);
        chk("rst_pass",     32'(pass),     32'd0);
        chk("rst_fail",     32'(fail),     32'd0);
        chk("rst_cfg_err",  32'(cfg_err),  32'd0);
        chk("rst_cur_step", 32'(cur_step), 32'd0);
        chk("rst_pass_cnt", 32'(pass_cnt), 32'd0);
        chk("rst_fail_cnt", 32'(fail_cnt), 32'd0);
        tick();
        rst_n = 1'b1;
        en    = 1'b1;
        tick();

        // Test 1: default chain ev0 ##1 ev1 ##1 ev2 ##1 ev3
        ev = 4'b0001; tick();
        chk("t1_busy", 32'(busy), 32'd1);
        chk("t1_step1", 32'(cur_step), 32'd1);
        ev = 4'b0010; tick();
        chk("t1_step2", 32'(cur_step), 32'd2);
        ev = 4'b0100; tick();
        chk("t1_pass_early", 32'(pass), 32'd0);
        ev = 4'b1000; tick();
        chk("t1_pass", 32'(pass), 32'd1);
        chk("t1_pass_cnt", 32'(pass_cnt), 32'd1);
        chk("t1_idle", 32'(busy), 32'd0);
        ev = 4'b0000; tick();
        chk("t1_pulse_end", 32'(pass), 32'd0);

        // Test 2: step 1 missed
        ev = 4'b0001; tick();
        ev = 4'b0000; tick();
        chk("t2_fail", 32'(fail), 32'd1);
        chk("t2_fail_step", 32'(fail_step), 32'd1);
        chk("t2_fail_cnt", 32'(fail_cnt), 32'd1);
        chk("t2_busy", 32'(busy), 32'd0);
        tick();
        chk("t2_fail_end", 32'(fail), 32'd0);
        chk("t2_step_held", 32'(fail_step), 32'd1);

        // Test 3: step 2 window [2,4]
        load_cfg(8'hE4, 16'h1210, 16'h1410);
        chk("t3_cfg_err", 32'(cfg_err), 32'd0);
        chk("t3_no_abort", 32'(abort), 32'd0);
        ev = 4'b0001; tick();
        ev = 4'b0010; tick();
        ev = 4'b0000; tick();
        ev = 4'b0000; tick();
        ev = 4'b0100; tick();
        chk("t3_win_step3", 32'(cur_step), 32'd3);
        ev = 4'b1000; tick();
        chk("t3_pass", 32'(pass), 32'd1);
        chk("t3_pass_cnt", 32'(pass_cnt), 32'd2);
        ev = 4'b0000; tick();
        ev = 4'b0001; tick();
        ev = 4'b0010; tick();
        ev = 4'b0100; tick();
        chk("t3_early_ignored", 32'(cur_step), 32'd2);
        ev = 4'b0000; tick();
        ev = 4'b0000; tick();
        chk("t3_still_busy", 32'(busy), 32'd1);
        ev = 4'b0000; tick();
        chk("t3_fail", 32'(fail), 32'd1);
        chk("t3_fail_step", 32'(fail_step), 32'd2);
        chk("t3_fail_cnt", 32'(fail_cnt), 32'd2);
        tick();

        // Test 4: cover mode drops the miss silently
        load_cfg(8'hE4, 16'h1110, 16'h1110);
        mode = 1'b1;
        ev = 4'b0001; tick();
        ev = 4'b0000; tick();
        chk("t4_no_fail", 32'(fail), 32'd0);
        chk("t4_fail_cnt", 32'(fail_cnt), 32'd2);
        chk("t4_busy", 32'(busy), 32'd0);
        chk("t4_step_held", 32'(fail_step), 32'd2);
        mode = 1'b0;
        tick();

        // Test 5: abort by en low, then invalid table blocks triggers
        ev = 4'b0001; tick();
        ev = 4'b0010; tick();
        chk("t5_step2", 32'(cur_step), 32'd2);
        en = 1'b0;
        ev = 4'b0000; tick();
        chk("t5_abort", 32'(abort), 32'd1);
        chk("t5_busy", 32'(busy), 32'd0);
        chk("t5_no_pass", 32'(pass), 32'd0);
        chk("t5_no_fail", 32'(fail), 32'd0);
        chk("t5_pass_cnt", 32'(pass_cnt), 32'd2);
        chk("t5_fail_cnt", 32'(fail_cnt), 32'd2);
        en = 1'b1; tick();
        chk("t5_abort_end", 32'(abort), 32'd0);
        load_cfg(8'hE4, 16'h1130, 16'h1120);
        chk("t5_cfg_err", 32'(cfg_err), 32'd1);
        ev = 4'b0001; tick();
        chk("t5_trig_ignored", 32'(busy), 32'd0);
        ev = 4'b0000;
        load_cfg(8'hE4, 16'h1110, 16'h1110);
        chk("t5_cfg_ok", 32'(cfg_err), 32'd0);

        // Test 6: 2-bit counters saturate; async reset mid-attempt
        chk("t6_s_cnt_before", 32'(s_pass_cnt), 32'd2);
        default_pass("t6a");
        chk("t6_s_cnt3", 32'(s_pass_cnt), 32'd3);
        default_pass("t6b");
        default_pass("t6c");
        chk("t6_s_sat", 32'(s_pass_cnt), 32'd3);
        chk("t6_wide_cnt", 32'(pass_cnt), 32'd5);
        chk("t6_s_fail_cnt", 32'(s_fail_cnt), 32'd2);
        ev = 4'b0001; tick();
        ev = 4'b0010; tick();
        chk("t6_busy_pre", 32'(busy), 32'd1);
        ev = 4'b0000;
        rst_n = 1'b0;
        #1;
        chk("t6_rst_busy", 32'(busy), 32'd0);
        chk("t6_rst_step", 32'(cur_step), 32'd0);
        chk("t6_rst_pass_cnt", 32'(pass_cnt), 32'd0);
        chk("t6_rst_fail_cnt", 32'(fail_cnt), 32'd0);
        chk("t6_rst_s_cnt", 32'(s_pass_cnt), 32'd0);
        #2;
        rst_n = 1'b1;
        tick();
        default_pass("t6d");
        chk("t6_after_rst_cnt", 32'(pass_cnt), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
